tdm_demux_2ch: RTL
==================

Name: tdm_demux_2ch

Overview:
- Receive end of the 2:1 channel mux: takes one time-interleaved word stream (ch0, ch1, ch0, ch1, ...) framed by a sync flag and splits it back into two independent channel streams.
- Per-channel FIFO buffering with valid/ready handshake on all sides.
- A small framing FSM tracks which channel is expected next and flags framing errors.
- Sits between the channel mux / serial link front end and the two per-channel consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, entries per channel FIFO; power of 2, minimum 2.
- CW, 3, occupancy count width = log2(DEPTH)+1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  interleaved word.
- in_valid  input  1  in_data valid.
- in_sync  input  1  qualifies in_data; marks a ch0 word (frame start).
- in_ready  output  1  block can accept the current word.
- out0_data  output  WIDTH  ch0 FIFO head.
- out0_valid  output  1  ch0 FIFO non-empty.
- out0_ready  input  1  ch0 consumer accepts.
- out1_data  output  WIDTH  ch1 FIFO head.
- out1_valid  output  1  ch1 FIFO non-empty.
- out1_ready  input  1  ch1 consumer accepts.
- state_dbg  output  2  FSM state: 00 = HUNT, 01 = EXP0, 10 = EXP1.
- sync_err  output  1  sticky framing-error flag.
- drop_cnt  output  8  words discarded in HUNT; saturates at 255.
- cnt0, cnt1  output  CW  FIFO occupancies.

Behaviour:
- Handshakes:
  - A word is accepted when in_valid & in_ready. A word is popped when outN_valid & outN_ready.
  - in_data and in_sync must hold stable while in_valid=1 and in_ready=0.
- Reset (synchronous, also when asserted mid-operation, overrides all activity in that cycle):
  - state = HUNT; both FIFOs flushed (cnt0 = cnt1 = 0, out0_valid = out1_valid = 0).
  - sync_err = 0, drop_cnt = 0.
  - outN_data = 0 after reset until the first write.
- FSM:
  - HUNT: a non-sync word is accepted and discarded, drop_cnt++ (stays in HUNT). A sync word is routed to ch0, go to EXP1.
  - EXP0: any word is routed to ch0, go to EXP1. in_sync here is normal.
  - EXP1, non-sync word: routed to ch1, go to EXP0.
  - EXP1, sync word: framing error. Set sync_err; route the word to ch0 (resynchronise); stay in EXP1.
  - No state change unless a word is accepted.
- Target channel: tgt = 0 if in_sync or state == EXP0; tgt = 1 if state == EXP1 and !in_sync; none for a non-sync word in HUNT.
- in_ready:
  - 1 for a non-sync word in HUNT.
  - Otherwise !full(tgt), where full means cnt == DEPTH.
  - Combinational from state, in_sync and counts only; never depends on outN_ready.
  - A pop in the same cycle does not free the slot for that cycle's push.
- Latency: a word accepted in cycle N is visible on outN_data/outN_valid in cycle N+1. No combinational path from input to output.
- FIFOs:
  - Circular buffers with wrap-around read/write pointers.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged and preserves order.
  - Pop on empty is impossible (valid = 0). Push on full is impossible (ready = 0).
  - A full FIFO back-pressures only words destined for it; the FSM stalls in its current state.
- Counters and flags:
  - drop_cnt holds at 255.
  - sync_err is cleared only by rst.

Test Plan:
- Reset, then sync word 0x11 followed by 0x22, 0x33, 0x44 (sync only on 0x11 and 0x33), outputs always ready -> out0 delivers 0x11, 0x33; out1 delivers 0x22, 0x44; each 1 cycle after acceptance; sync_err = 0; state ends at EXP0.
- Three non-sync words 0xA0..0xA2 after reset, then sync 0x55 -> drop_cnt = 3; only 0x55 appears, on out0; state = EXP1.
- Sync 0x01, then sync 0x02 (while in EXP1), then non-sync 0x03 -> out0 = 0x01, 0x02; out1 = 0x03; sync_err = 1 and stays 1 until rst.
- out1_ready = 0, stream 5 frames (DEPTH = 4) -> cnt1 reaches 4; in_ready = 0 when the 5th ch1 word is presented (FSM stalls in EXP1); raising out1_ready drains ch1 in order; ch0 data intact.
- Full ch0 with simultaneous pop and push attempt -> push refused that cycle (in_ready = 0), cnt0 goes 4 -> 3, push accepted the next cycle.
- Assert rst for 1 cycle with both FIFOs holding 2 words -> next cycle cnt0 = cnt1 = 0, out valids = 0, state = HUNT, sync_err = 0, drop_cnt = 0.

Source files
------------

// File: rtl/tdm_demux_2ch.sv
// tdm_demux_2ch: splits an interleaved ch0/ch1 word stream (ch0 marked by in_sync)
// into two independently buffered channel streams. A small framing FSM tracks the
// expected channel, discards words while hunting for sync and flags framing errors.
module tdm_demux_2ch #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [1:0]       state_dbg,
  output logic             sync_err,
  output logic [7:0]       drop_cnt,
  output logic [CW-1:0]    cnt0,
  output logic [CW-1:0]    cnt1
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] StHunt = 2'b00;
  localparam logic [1:0] StExp0 = 2'b01;
  localparam logic [1:0] StExp1 = 2'b10;

  logic [1:0]       state_q, state_d;
  logic             sync_err_q, sync_err_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [WIDTH-1:0] mem_d  [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];

  logic       hunt_drop;
  logic       tgt1;
  logic       accept;
  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;

  // Routing decode and handshakes; in_ready deliberately ignores the consumer readies
  always_comb begin
    hunt_drop = (state_q == StHunt) && !in_sync;
    tgt1      = (state_q == StExp1) && !in_sync;
    for (int ch = 0; ch < 2; ch++) begin
      full[ch]  = (cnt_q[ch] == CW'(DEPTH));
      valid[ch] = (cnt_q[ch] != '0);
    end
    in_ready = hunt_drop | (tgt1 ? !full[1] : !full[0]);
    accept   = in_valid & in_ready;
    push[0]  = accept & !hunt_drop & !tgt1;
    push[1]  = accept & tgt1;
    pop[0]   = valid[0] & out0_ready;
    pop[1]   = valid[1] & out1_ready;
  end

  // Framing FSM, sticky error flag and saturating drop counter; only advances on accept
  always_comb begin
    state_d    = state_q;
    sync_err_d = sync_err_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      case (state_q)
        StHunt: begin
          if (in_sync) begin
            state_d = StExp1;
          end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
          end
        end
        StExp0: state_d = StExp1;
        StExp1: begin
          // A sync word here resynchronises onto ch0 without leaving EXP1
          if (in_sync) begin
            sync_err_d = 1'b1;
          end else begin
            state_d = StExp0;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // Per-channel circular FIFOs; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    mem_d = mem_q;
    for (int ch = 0; ch < 2; ch++) begin
      wptr_d[ch] = wptr_q[ch];
      rptr_d[ch] = rptr_q[ch];
      if (push[ch]) begin
        mem_d[ch][wptr_q[ch]] = in_data;
        wptr_d[ch]            = wptr_q[ch] + PW'(1);
      end
      if (pop[ch]) begin
        rptr_d[ch] = rptr_q[ch] + PW'(1);
      end
      cnt_d[ch] = cnt_q[ch] + CW'(push[ch]) - CW'(pop[ch]);
    end
  end

  // State registers; storage is cleared too so the heads read zero until first write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHunt;
      sync_err_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      mem_q      <= '{default: '0};
      wptr_q     <= '{default: '0};
      rptr_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      sync_err_q <= sync_err_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out0_data  = mem_q[0][rptr_q[0]];
  assign out1_data  = mem_q[1][rptr_q[1]];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign state_dbg  = state_q;
  assign sync_err   = sync_err_q;
  assign drop_cnt   = drop_cnt_q;
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule
